// File: rtl/mem_write_checker_pkg.sv
// Shared types for the memory-write self-check monitor: FSM states, the
// default-width table entry layout and the default cycle budget.
package mem_write_checker_pkg;

    localparam int DEFAULT_ADDR_W  = 32;
    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_TIMEOUT = 1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TMO
    } mwcState_t;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [DEFAULT_DATA_W-1:0] data;
    } mwcEntry_t;

endpackage

// File: rtl/mwc_table.sv
// Expected-write table: DEPTH entries, one synchronous write port and one
// asynchronous read port. Out-of-range indices are ignored / read as zero.
module mwc_table #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int IDX_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  wrIdx,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [IDX_W-1:0]  rdIdx,
    output logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t mem [DEPTH];

    // Index compare per entry keeps DEPTH=1 (zero-width select) legal.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
            if (we && (wrIdx == IDX_W'(i))) begin
                mem[i] <= '{addr: wrAddr, data: wrData};
            end
        end
    end

    always_comb begin
        rdAddr = '0;
        rdData = '0;
        for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
            if (rdIdx == IDX_W'(i)) begin
                rdAddr = mem[i].addr;
                rdData = mem[i].data;
            end
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Data-memory write bus monitor: matches stores against an ordered table with
// a whole-run cycle budget. Optional MEM_WRITE_CHECKER_STATS_EN adds store stats.
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int IDX_W   = $clog2(DEPTH) + 1,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TMO_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [IDX_W-1:0]  cfg_count,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [IDX_W-1:0]  match_idx,
    output logic [DATA_W-1:0] bad_data
`ifdef MEM_WRITE_CHECKER_STATS_EN
    ,
    output logic [31:0]       store_cnt,
    output logic [ADDR_W-1:0] first_adr
`endif
);

    mwcState_t         state, stateNext;
    logic [IDX_W-1:0]  matchIdx, matchIdxNext;
    logic [IDX_W-1:0]  runCount, runCountNext;
    logic [DATA_W-1:0] badData, badDataNext;
    logic [TMO_W-1:0]  tmoCnt, tmoCntNext;

    logic [ADDR_W-1:0] curAddr;
    logic [DATA_W-1:0] curData;
    logic              tableWe;
    logic [IDX_W-1:0]  clampedCount;
    logic [IDX_W-1:0]  matchInc;
    logic              addrHit;
    logic              dataHit;

    assign tableWe      = cfg_we && (state == ST_IDLE);
    assign clampedCount = (cfg_count > IDX_W'(DEPTH)) ? IDX_W'(DEPTH) : cfg_count;
    assign matchInc     = matchIdx + IDX_W'(1);
    assign addrHit      = MemWrite && (DataAdr == curAddr);
    assign dataHit      = (WriteData == curData);

    mwc_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_table (
        .clk    (clk),
        .we     (tableWe),
        .wrIdx  (cfg_idx),
        .wrAddr (cfg_addr),
        .wrData (cfg_data),
        .rdIdx  (matchIdx),
        .rdAddr (curAddr),
        .rdData (curData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            matchIdx <= '0;
            runCount <= '0;
            badData  <= '0;
            tmoCnt   <= '0;
        end else begin
            state    <= stateNext;
            matchIdx <= matchIdxNext;
            runCount <= runCountNext;
            badData  <= badDataNext;
            tmoCnt   <= tmoCntNext;
        end
    end

    always_comb begin
        stateNext    = state;
        matchIdxNext = matchIdx;
        runCountNext = runCount;
        badDataNext  = badData;
        tmoCntNext   = tmoCnt;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    runCountNext = clampedCount;
                    matchIdxNext = '0;
                    tmoCntNext   = '0;
                    badDataNext  = '0;
                    stateNext    = (clampedCount == '0) ? ST_PASS : ST_RUN;
                end
            end
            ST_RUN: begin
                // Match beats mismatch beats budget expiry on the same edge.
                if (addrHit && dataHit) begin
                    matchIdxNext = matchInc;
                    if (matchInc == runCount) begin
                        stateNext = ST_PASS;
                    end
                end else if (addrHit) begin
                    stateNext   = ST_FAIL;
                    badDataNext = WriteData;
                end else begin
                    tmoCntNext = tmoCnt + TMO_W'(1);
                    if (tmoCnt == TMO_W'(TIMEOUT - 1)) begin
                        stateNext = ST_TMO;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy      = (state == ST_RUN);
    assign pass      = (state == ST_PASS);
    assign fail      = (state == ST_FAIL);
    assign timeout   = (state == ST_TMO);
    assign done      = pass || fail || timeout;
    assign match_idx = matchIdx;
    assign bad_data  = badData;

`ifdef MEM_WRITE_CHECKER_STATS_EN
    logic [31:0]       storeCnt, storeCntNext;
    logic [ADDR_W-1:0] firstAdr, firstAdrNext;
    logic              firstSeen, firstSeenNext;

    always_ff @(posedge clk) begin
        if (reset) begin
            storeCnt  <= '0;
            firstAdr  <= '0;
            firstSeen <= 1'b0;
        end else begin
            storeCnt  <= storeCntNext;
            firstAdr  <= firstAdrNext;
            firstSeen <= firstSeenNext;
        end
    end

    always_comb begin
        storeCntNext  = storeCnt;
        firstAdrNext  = firstAdr;
        firstSeenNext = firstSeen;
        if ((state == ST_IDLE) && start) begin
            storeCntNext  = '0;
            firstAdrNext  = '0;
            firstSeenNext = 1'b0;
        end else if ((state == ST_RUN) && MemWrite) begin
            if (storeCnt != '1) begin
                storeCntNext = storeCnt + 32'd1;
            end
            if (!firstSeen) begin
                firstAdrNext  = DataAdr;
                firstSeenNext = 1'b1;
            end
        end
    end

    assign store_cnt = storeCnt;
    assign first_adr = firstAdr;
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Self-checking bench for mem_write_checker: directed scenarios plus randomized
// runs against a table-walking reference model. Stats checks follow MEM_WRITE_CHECKER_STATS_EN.
module tb_mem_write_checker;

    localparam int DEPTH   = 4;
    localparam int IDX_W   = 3;
    localparam int TIMEOUT = 20;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_data;
    logic [2:0]  cfg_count;
    logic        start;
    logic        busy, done, pass, fail, timeout;
    logic [2:0]  match_idx;
    logic [31:0] bad_data;
`ifdef MEM_WRITE_CHECKER_STATS_EN
    logic [31:0] store_cnt;
    logic [31:0] first_adr;
`endif

    int asserts = 0;
    int fails   = 0;

    mem_write_checker #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .DEPTH   (DEPTH),
        .IDX_W   (IDX_W),
        .TIMEOUT (TIMEOUT),
        .TMO_W   (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_count (cfg_count),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .timeout   (timeout),
        .match_idx (match_idx),
        .bad_data  (bad_data)
`ifdef MEM_WRITE_CHECKER_STATS_EN
        ,
        .store_cnt (store_cnt),
        .first_adr (first_adr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_addr  = '0;
        cfg_data  = '0;
        cfg_count = '0;
        start     = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic writeEntry(input int idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_idx  = 3'(idx);
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic startRun(input int cnt);
        cfg_count = 3'(cnt);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic test_reset();
        clearInputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        asserts++;
        if ({busy, done, pass, fail, timeout} !== 5'b0) begin
            fails++;
            $display("FAIL reset_status: got %b expected 00000", {busy, done, pass, fail, timeout});
        end
        asserts++;
        if (match_idx !== 3'd0 || bad_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_idx_bad: got idx=%0d bad=%0h expected 0/0", match_idx, bad_data);
        end
`ifdef MEM_WRITE_CHECKER_STATS_EN
        asserts++;
        if (store_cnt !== 32'd0 || first_adr !== 32'd0) begin
            fails++;
            $display("FAIL reset_stats: got cnt=%0d first=%0h expected 0/0", store_cnt, first_adr);
        end
`endif
    endtask

    task automatic test_single_pass();
        doReset();
        writeEntry(0, 32'd128, 32'd254);
        startRun(1);
        asserts++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL single_busy: got %b expected 1", busy);
        end
        store(32'd100, 32'd7);
        asserts++;
        if (busy !== 1'b1 || pass !== 1'b0 || match_idx !== 3'd0) begin
            fails++;
            $display("FAIL single_ignored: got busy=%b pass=%b idx=%0d expected 1/0/0", busy, pass, match_idx);
        end
        store(32'd128, 32'd254);
        asserts++;
        if ({busy, done, pass, fail, timeout} !== 5'b01100 || match_idx !== 3'd1) begin
            fails++;
            $display("FAIL single_pass: got st=%b idx=%0d expected 01100/1", {busy, done, pass, fail, timeout}, match_idx);
        end
        startRun(1);
        store(32'd128, 32'd1);
        asserts++;
        if (pass !== 1'b1 || fail !== 1'b0 || match_idx !== 3'd1) begin
            fails++;
            $display("FAIL single_sticky: got pass=%b fail=%b idx=%0d expected 1/0/1", pass, fail, match_idx);
        end
    endtask

    task automatic test_mismatch();
        doReset();
        writeEntry(0, 32'd128, 32'd254);
        startRun(1);
        store(32'd128, 32'd253);
        asserts++;
        if ({busy, done, pass, fail, timeout} !== 5'b01010 || match_idx !== 3'd0 || bad_data !== 32'd253) begin
            fails++;
            $display("FAIL mismatch: got st=%b idx=%0d bad=%0d expected 01010/0/253",
                     {busy, done, pass, fail, timeout}, match_idx, bad_data);
        end
        store(32'd128, 32'd254);
        asserts++;
        if (fail !== 1'b1 || pass !== 1'b0 || bad_data !== 32'd253) begin
            fails++;
            $display("FAIL mismatch_sticky: got fail=%b pass=%b bad=%0d expected 1/0/253", fail, pass, bad_data);
        end
    endtask

    task automatic test_ordered();
        logic [2:0] expIdx [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        logic [31:0] sa [4] = '{32'h84, 32'h80, 32'h84, 32'h80};
        logic [31:0] sd [4] = '{32'd2, 32'd1, 32'd2, 32'd3};
        doReset();
        writeEntry(0, 32'h80, 32'd1);
        writeEntry(1, 32'h84, 32'd2);
        writeEntry(2, 32'h80, 32'd3);
        startRun(3);
        for (int i = 0; i < 4; i++) begin
            store(sa[i], sd[i]);
            asserts++;
            if (match_idx !== expIdx[i] || pass !== (i == 3)) begin
                fails++;
                $display("FAIL ordered_step%0d: got idx=%0d pass=%b expected %0d/%b",
                         i, match_idx, pass, expIdx[i], (i == 3));
            end
        end
    endtask

    task automatic test_timeout();
        doReset();
        writeEntry(0, 32'h200, 32'h55);
        startRun(1);
        repeat (TIMEOUT - 1) tick();
        asserts++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL timeout_early: got tmo=%b busy=%b expected 0/1", timeout, busy);
        end
        tick();
        asserts++;
        if ({busy, done, pass, fail, timeout} !== 5'b01001) begin
            fails++;
            $display("FAIL timeout_fire: got %b expected 01001", {busy, done, pass, fail, timeout});
        end
        doReset();
        writeEntry(0, 32'h200, 32'h55);
        startRun(1);
        repeat (TIMEOUT - 1) tick();
        store(32'h200, 32'h55);
        asserts++;
        if (pass !== 1'b1 || timeout !== 1'b0) begin
            fails++;
            $display("FAIL timeout_match_wins: got pass=%b tmo=%b expected 1/0", pass, timeout);
        end
    endtask

    task automatic test_reset_mid_run();
        doReset();
        writeEntry(0, 32'h10, 32'd1);
        writeEntry(1, 32'h14, 32'd2);
        startRun(2);
        store(32'h10, 32'd1);
        asserts++;
        if (match_idx !== 3'd1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL midrun_progress: got idx=%0d busy=%b expected 1/1", match_idx, busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        asserts++;
        if ({busy, done, pass, fail, timeout} !== 5'b0 || match_idx !== 3'd0) begin
            fails++;
            $display("FAIL midrun_reset: got st=%b idx=%0d expected 00000/0", {busy, done, pass, fail, timeout}, match_idx);
        end
        writeEntry(0, 32'h20, 32'd5);
        writeEntry(1, 32'h24, 32'd6);
        startRun(2);
        store(32'h20, 32'd5);
        asserts++;
        if (match_idx !== 3'd1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL midrun_restart: got idx=%0d busy=%b expected 1/1", match_idx, busy);
        end
        doReset();
        startRun(0);
        asserts++;
        if ({busy, done, pass, fail, timeout} !== 5'b01100 || match_idx !== 3'd0) begin
            fails++;
            $display("FAIL zero_count: got st=%b idx=%0d expected 01100/0", {busy, done, pass, fail, timeout}, match_idx);
        end
    endtask

    task automatic test_clamp();
        doReset();
        for (int i = 0; i < DEPTH; i++) writeEntry(i, 32'h300 + 32'(i * 4), 32'(i + 10));
        writeEntry(5, 32'h300, 32'd99);
        startRun(7);
        for (int i = 0; i < DEPTH; i++) store(32'h300 + 32'(i * 4), 32'(i + 10));
        asserts++;
        if (pass !== 1'b1 || match_idx !== 3'd4) begin
            fails++;
            $display("FAIL clamp: got pass=%b idx=%0d expected 1/4", pass, match_idx);
        end
    endtask

`ifdef MEM_WRITE_CHECKER_STATS_EN
    task automatic test_stats();
        doReset();
        writeEntry(0, 32'h100, 32'd1);
        startRun(1);
        store(32'h40, 32'd5);
        store(32'h44, 32'd6);
        store(32'h48, 32'd7);
        store(32'h4C, 32'd8);
        store(32'h100, 32'd1);
        store(32'h50, 32'd9);
        asserts++;
        if (store_cnt !== 32'd5 || first_adr !== 32'h40 || pass !== 1'b1) begin
            fails++;
            $display("FAIL stats: got cnt=%0d first=%0h pass=%b expected 5/40/1", store_cnt, first_adr, pass);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] addrSet [3] = '{32'h10, 32'h14, 32'h18};
        logic [31:0] mA [DEPTH];
        logic [31:0] mD [DEPTH];
        int          effCnt, st, idx, nonMatch, wi, cnt;
        logic [31:0] bad, sc, fa, a, d;
        logic        seen, drvWe;
        logic [4:0]  expVec;
        for (int it = 0; it < 40; it++) begin
            clearInputs();
            doReset();
            for (int i = 0; i < DEPTH; i++) begin
                mA[i] = addrSet[$urandom_range(0, 2)];
                mD[i] = 32'($urandom_range(0, 3));
                writeEntry(i, mA[i], mD[i]);
            end
            for (int k = 0; k < 2; k++) begin
                wi = $urandom_range(0, 5);
                a  = addrSet[$urandom_range(0, 2)];
                d  = 32'($urandom_range(0, 3));
                if (wi < DEPTH) begin
                    mA[wi] = a;
                    mD[wi] = d;
                end
                writeEntry(wi, a, d);
            end
            cnt    = $urandom_range(0, 6);
            effCnt = (cnt > DEPTH) ? DEPTH : cnt;
            if ($urandom_range(0, 3) == 0) begin
                cfg_we   = 1'b1;
                cfg_idx  = 3'd0;
                cfg_addr = addrSet[$urandom_range(0, 2)];
                cfg_data = 32'($urandom_range(0, 3));
                mA[0]    = cfg_addr;
                mD[0]    = cfg_data;
            end
            startRun(cnt);
            cfg_we   = 1'b0;
            st       = (effCnt == 0) ? 1 : 0;
            idx      = 0;
            nonMatch = 0;
            bad      = '0;
            sc       = '0;
            fa       = '0;
            seen     = 1'b0;
            for (int cyc = 0; cyc < 30; cyc++) begin
                drvWe = ($urandom_range(0, 1) == 1);
                a     = addrSet[$urandom_range(0, 2)];
                d     = (idx < DEPTH && $urandom_range(0, 3) != 0) ? mD[idx] : 32'($urandom_range(0, 3));
                MemWrite  = drvWe;
                DataAdr   = a;
                WriteData = d;
                if ($urandom_range(0, 7) == 0) begin
                    cfg_we    = 1'b1;
                    cfg_idx   = 3'($urandom_range(0, 3));
                    cfg_addr  = addrSet[$urandom_range(0, 2)];
                    cfg_data  = 32'($urandom_range(0, 3));
                    start     = 1'b1;
                    cfg_count = 3'($urandom_range(0, 4));
                end
                tick();
                cfg_we = 1'b0;
                start  = 1'b0;
                if (st == 0) begin
                    if (drvWe) begin
                        if (sc != 32'hFFFF_FFFF) sc = sc + 1;
                        if (!seen) begin
                            seen = 1'b1;
                            fa   = a;
                        end
                    end
                    if (drvWe && a == mA[idx]) begin
                        if (d == mD[idx]) begin
                            idx++;
                            if (idx == effCnt) st = 1;
                        end else begin
                            st  = 2;
                            bad = d;
                        end
                    end else begin
                        nonMatch++;
                        if (nonMatch == TIMEOUT) st = 3;
                    end
                end
                expVec = {st == 0, st != 0, st == 1, st == 2, st == 3};
                asserts++;
                if ({busy, done, pass, fail, timeout} !== expVec || match_idx !== 3'(idx) || bad_data !== bad) begin
                    fails++;
                    $display("FAIL random it%0d cyc%0d: got st=%b idx=%0d bad=%0d expected %b/%0d/%0d",
                             it, cyc, {busy, done, pass, fail, timeout}, match_idx, bad_data, expVec, idx, bad);
                end
`ifdef MEM_WRITE_CHECKER_STATS_EN
                asserts++;
                if (store_cnt !== sc || first_adr !== fa) begin
                    fails++;
                    $display("FAIL random_stats it%0d cyc%0d: got cnt=%0d first=%0h expected %0d/%0h",
                             it, cyc, store_cnt, first_adr, sc, fa);
                end
`endif
            end
            MemWrite = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        clearInputs();
        test_reset();
        test_single_pass();
        test_mismatch();
        test_ordered();
        test_timeout();
        test_reset_mid_run();
        test_clamp();
`ifdef MEM_WRITE_CHECKER_STATS_EN
        test_stats();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable, parametrised self-check monitor for single-cycle/multicycle ARM cores; sits beside top, snooping the data-memory write bus (MemWrite, DataAdr, WriteData).
- Replaces a fixed "one address, one value" pass criterion with a programmable ordered table of expected writes, a cycle timeout and sticky pass/fail/timeout status.
- Usable in benches and on FPGA (status to LEDs).

Parameters:
ADDR_W, 32, width of DataAdr
DATA_W, 32, width of WriteData
DEPTH, 4, number of expected-write table entries (>=1)
IDX_W, $clog2(DEPTH)+1, index/count width (holds 0..DEPTH)
TIMEOUT, 1000, cycles allowed in RUN before timeout (>=1)
TMO_W, 32, timeout counter width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
MemWrite  in  1  core store strobe, sampled each rising edge
DataAdr  in  ADDR_W  store address
WriteData  in  DATA_W  store data
cfg_we  in  1  write table entry (accepted only in IDLE)
cfg_idx  in  IDX_W  entry index, 0..DEPTH-1; out-of-range ignored
cfg_addr  in  ADDR_W  expected address
cfg_data  in  DATA_W  expected data
cfg_count  in  IDX_W  number of valid entries, latched on start; clamped to DEPTH
start  in  1  IDLE->RUN
busy  out  1  state==RUN
done  out  1  state in {PASS, FAIL, TMO}
pass  out  1  state==PASS
fail  out  1  state==FAIL
timeout  out  1  state==TMO
match_idx  out  IDX_W  entries matched so far / failing index
bad_data  out  DATA_W  WriteData captured on mismatch, else 0

Behaviour:
- States: IDLE, RUN, PASS, FAIL, TMO (encoding in package).
- Reset: state=IDLE, match_idx=0, bad_data=0, timeout counter=0, latched count=0; all status outputs 0. Table RAM is not cleared (contents undefined until programmed).
- IDLE: cfg_we writes table[cfg_idx] next edge. start: latch count=min(cfg_count, DEPTH), match_idx=0, counter=0.
  - If latched count==0: go to PASS.
  - Otherwise go to RUN.
  - cfg_we and start in the same cycle: the write completes; RUN uses the new entry.
- RUN, per edge, priority order:
  1. MemWrite && DataAdr==table[match_idx].addr && WriteData==table[match_idx].data: match_idx+1. If that reaches count, go to PASS.
  2. MemWrite && address matches && data differs: go to FAIL, bad_data=WriteData, match_idx held.
  3. Otherwise counter+1. If counter reaches TIMEOUT-1 with no match this cycle, go to TMO.
- Stores to addresses other than the current entry's are ignored, including addresses of later entries. Ordering is strict on the current entry only.
- Duplicate addresses in the table are matched in order.
- Counter does not reset on a match. It is a whole-run budget.
- A match on the same edge the timeout would fire wins: status is PASS, or RUN continues.
- PASS, FAIL, TMO are sticky; outputs are held. start is ignored there. Only reset returns to IDLE.
- start and cfg_we outside IDLE are ignored.
- Reset mid-RUN: IDLE next edge, no partial status visible.
- Status outputs are registered: visible the cycle after the deciding edge.
- Comparisons use ==. X/Z on the bus gives no match.

Optional Feature:
- Macro MEM_WRITE_CHECKER_STATS_EN.
- Defined:
  - adds output store_cnt (32 bits): count of all MemWrite cycles seen in RUN, saturating at all-ones, cleared on reset and on start.
  - adds output first_adr (ADDR_W): DataAdr of the first store in RUN, 0 if none.
- Not defined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package mem_write_checker_pkg: state enum (IDLE, RUN, PASS, FAIL, TMO), entry struct {addr, data} parameterised via localparam widths, default TIMEOUT constant.
- One sub-module, mwc_table: DEPTH-entry register file, 1 synchronous write port, 1 asynchronous read port indexed by match_idx.
- Top holds the FSM and counters.

Test Plan:
1. Program {128,254}, count=1, start; drive MemWrite at 100/7, then 128/254 -> pass=1 the cycle after the 128 store, match_idx=1, fail=0.
2. Program {128,254}; drive store 128/253 -> fail=1, match_idx=0, bad_data=253; a later 128/254 leaves fail=1.
3. Program {0x80,1},{0x84,2},{0x80,3}; drive 0x84/2 (ignored), then 0x80/1, 0x84/2, 0x80/3 -> pass after the 4th store, match_idx=3.
4. TIMEOUT=20, count=1, no matching store -> timeout=1 exactly 20 cycles after RUN entry. Repeat with the matching store on cycle 20 -> pass=1, timeout=0.
5. Assert reset during RUN after 1 of 2 matches; re-program and start -> IDLE, all status 0, match_idx restarts at 0; count=0 start -> pass next cycle.
6. With MEM_WRITE_CHECKER_STATS_EN: 5 stores in RUN, first at 0x40 -> store_cnt=5, first_adr=0x40. Without the macro, the port list compiles without these ports.
